// File: rtl/cmos_frame_capture.sv
// cmos_frame_capture: assembles 2-byte camera pixels into RGB words, decimates, and writes them to
// VRAM with linear addressing, optionally ping-ponging between two frame regions.
// Ports:
//   clk_i, reset_ni       clock, async active-low reset
//   enable_i, mode_i      capture enable, pixel format (0/3 RGB565, 1 YUV422 grey, 2 RGB444)
//   byte_valid_i, vsync_i, href_i, data_i   synchronised camera byte stream
//   wr_en_o, wr_addr_o, wr_data_o           VRAM write port ({R,G,B})
//   display_sel_o, frame_done_o, error_o    buffer for display, clean-frame pulse, geometry error
module cmos_frame_capture #(
  parameter int unsigned ACTIVE_COLUMNS = 640,
  parameter int unsigned ACTIVE_ROWS    = 480,
  parameter int unsigned DECIMATION     = 2,
  parameter int unsigned CHANNEL_BITS   = 4,
  parameter int unsigned DOUBLE_BUFFER  = 1,
  localparam int unsigned FRAME_WORDS   = ACTIVE_COLUMNS * ACTIVE_ROWS / (DECIMATION * DECIMATION),
  localparam int unsigned ADDR_WIDTH    = $clog2((DOUBLE_BUFFER + 1) * FRAME_WORDS)
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        enable_i,
  input  logic [1:0]                  mode_i,
  input  logic                        byte_valid_i,
  input  logic                        vsync_i,
  input  logic                        href_i,
  input  logic [7:0]                  data_i,
  output logic                        wr_en_o,
  output logic [ADDR_WIDTH-1:0]       wr_addr_o,
  output logic [3*CHANNEL_BITS-1:0]   wr_data_o,
  output logic                        display_sel_o,
  output logic                        frame_done_o,
  output logic                        error_o
);

  localparam int unsigned LINE_BYTES = 2 * ACTIVE_COLUMNS;
  localparam int unsigned BCW        = $clog2(LINE_BYTES + 2);
  localparam int unsigned ROWW       = $clog2(ACTIVE_ROWS + 2);
  localparam int unsigned WW         = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned DW         = 3 * CHANNEL_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VS, ST_CAPTURE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic                  vsync_q, vsync_d;
  logic                  href_q, href_d;
  logic                  phase_q, phase_d;
  logic [7:0]            byte0_q, byte0_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [ROWW-1:0]       row_q, row_d;
  logic [WW-1:0]         word_q, word_d;
  logic                  wbuf_q, wbuf_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic                  display_sel_q, display_sel_d;
  logic                  frame_done_q, frame_done_d;
  logic                  error_q, error_d;

  logic                  vs_fall, vs_rise, href_fall, keep;
  logic [3:0]            r4, g4, b4;
  int unsigned           x_pos, y_pos;

  // Channel extraction from the stored first byte and the current second byte
  always_comb begin
    r4 = byte0_q[7:4];
    g4 = {byte0_q[2:0], data_i[7]};
    b4 = data_i[4:1];
    case (mode_q)
      2'd1: begin
        r4 = byte0_q[7:4];
        g4 = byte0_q[7:4];
        b4 = byte0_q[7:4];
      end
      2'd2: begin
        r4 = byte0_q[3:0];
        g4 = data_i[7:4];
        b4 = data_i[3:0];
      end
      default: ;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    vsync_d       = vsync_i;
    href_d        = byte_valid_i ? href_i : href_q;
    phase_d       = phase_q;
    byte0_d       = byte0_q;
    byte_cnt_d    = byte_cnt_q;
    row_d         = row_q;
    word_d        = word_q;
    wbuf_d        = wbuf_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    display_sel_d = display_sel_q;
    frame_done_d  = 1'b0;
    error_d       = error_q;

    vs_fall   = vsync_q & ~vsync_i;
    vs_rise   = ~vsync_q & vsync_i;
    href_fall = byte_valid_i & href_q & ~href_i;
    // Pixel x equals completed byte pairs; byte_cnt saturates past the line so x stays out of range
    x_pos     = 32'(byte_cnt_q >> 1);
    y_pos     = 32'(row_q);
    keep      = (x_pos < ACTIVE_COLUMNS) && (y_pos < ACTIVE_ROWS) &&
                ((x_pos % DECIMATION) == 32'd0) && ((y_pos % DECIMATION) == 32'd0);

    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (vs_fall) begin
          state_d    = ST_CAPTURE;
          mode_d     = mode_i;
          href_d     = 1'b0;
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          row_d      = '0;
          word_d     = '0;
          error_d    = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (href_fall) begin
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          if (row_q != ROWW'(ACTIVE_ROWS + 1)) row_d = row_q + ROWW'(1);
          if (byte_cnt_q != BCW'(LINE_BYTES)) error_d = 1'b1;
        end else if (byte_valid_i && href_i && !vs_rise) begin
          if (byte_cnt_q != BCW'(LINE_BYTES + 1)) byte_cnt_d = byte_cnt_q + BCW'(1);
          if (!phase_q) begin
            byte0_d = data_i;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (keep) begin
              wr_en_d   = 1'b1;
              wr_addr_d = (wbuf_q ? ADDR_WIDTH'(FRAME_WORDS) : '0) + ADDR_WIDTH'(word_q);
              wr_data_d = {r4[3 -: CHANNEL_BITS], g4[3 -: CHANNEL_BITS], b4[3 -: CHANNEL_BITS]};
              if (word_q != WW'(FRAME_WORDS - 1)) word_d = word_q + WW'(1);
            end
          end
        end
        // Frame check sees the row count and error already updated by a coincident href fall
        if (vs_rise) begin
          state_d = enable_i ? ST_WAIT_VS : ST_IDLE;
          if (row_d != ROWW'(ACTIVE_ROWS)) error_d = 1'b1;
          if (!error_d) begin
            frame_done_d = 1'b1;
            if (DOUBLE_BUFFER != 0) begin
              display_sel_d = wbuf_q;
              wbuf_d        = ~wbuf_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_IDLE;
      mode_q        <= 2'd0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      phase_q       <= 1'b0;
      byte0_q       <= 8'd0;
      byte_cnt_q    <= '0;
      row_q         <= '0;
      word_q        <= '0;
      wbuf_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      display_sel_q <= 1'b0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      phase_q       <= phase_d;
      byte0_q       <= byte0_d;
      byte_cnt_q    <= byte_cnt_d;
      row_q         <= row_d;
      word_q        <= word_d;
      wbuf_q        <= wbuf_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      display_sel_q <= display_sel_d;
      frame_done_q  <= frame_done_d;
      error_q       <= error_d;
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign display_sel_o = display_sel_q;
  assign frame_done_o  = frame_done_q;
  assign error_o       = error_q;

endmodule
